// File: rtl/fpu_pkg.sv
// Shared FPU issue definitions: the fadd pipeline latency and the shadow-entry
// record that follows each in-flight op through the issue arbiters.
package fpu_pkg;

  localparam int FADD_LAT     = 2;
  localparam int SHADOW_ID_W  = 2;   // enough for up to 4 requesters
  localparam int SHADOW_TAG_W = 16;  // widest destination tag carried

  typedef struct packed {
    logic                    v;
    logic [SHADOW_ID_W-1:0]  id;
    logic [SHADOW_TAG_W-1:0] tag;
  } shadow_entry_t;

  // The shadow pipe only lines up with fadd_y if its depth equals the unit's latency.
  function automatic bit fadd_lat_ok(input int lat);
    return lat == FADD_LAT;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after ptr (mod NREQ) and
// returns it as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Search starts one past the last winner, so the last winner gets lowest priority.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    if (enable) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDX_W'((int'(ptr) + k) % NREQ);
        if (!any && req[cand]) begin
          any         = 1'b1;
          grant[cand] = 1'b1;
          idx         = cand;
        end
      end
    end
  end

endmodule

// File: rtl/fadd_issue_arbiter.sv
// Shares one pipelined fadd between NREQ requesters and routes each result
// back to its originator with its tag, via a shadow pipe as deep as the fadd.
module fadd_issue_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 6,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_x1,
  input  logic [NREQ*32-1:0]      req_x2,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  input  logic                    flush,
  output logic [31:0]             fadd_x1,
  output logic [31:0]             fadd_x2,
  input  logic [31:0]             fadd_y,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [31:0]             rsp_y,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (!fadd_lat_ok(LAT)) begin : g_lat_check
    $error("fadd_issue_arbiter: LAT must equal fpu_pkg::FADD_LAT");
  end
  if (NREQ < 2 || NREQ > 4) begin : g_nreq_check
    $error("fadd_issue_arbiter: NREQ must be in 2..4");
  end
  if (TAG_W > SHADOW_TAG_W) begin : g_tag_check
    $error("fadd_issue_arbiter: TAG_W exceeds shadow tag width");
  end

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr;
  logic             gnt_any;
  logic             issue_en;
  logic [TAG_W-1:0] issue_tag;

  shadow_entry_t shadow [LAT];
  shadow_entry_t last;
  logic          shadow_unused;

  assign issue_en = !rst && !flush;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .enable (issue_en),
    .grant  (grant),
    .idx    (gnt_idx),
    .any    (gnt_any)
  );

  assign req_ready = grant;

  // Idle cycles feed fadd(0,0) so the datapath does not toggle.
  always_comb begin
    fadd_x1   = '0;
    fadd_x2   = '0;
    issue_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        fadd_x1   = req_x1[32*i +: 32];
        fadd_x2   = req_x2[32*i +: 32];
        issue_tag = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(NREQ - 1);
    end else if (gnt_any) begin
      ptr <= gnt_idx;
    end
  end

  // Reset and flush both squash every in-flight entry; ops already issued never return.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < LAT; s++) begin
        shadow[s] <= '0;
      end
    end else begin
      shadow[0] <= '{v:   gnt_any,
                     id:  SHADOW_ID_W'(gnt_idx),
                     tag: SHADOW_TAG_W'(issue_tag)};
      for (int s = 1; s < LAT; s++) begin
        shadow[s] <= shadow[s-1];
      end
    end
  end

  assign last          = shadow[LAT-1];
  assign shadow_unused = ^last;

  always_comb begin
    rsp_valid = '0;
    rsp_y     = '0;
    rsp_tag   = '0;
    if (last.v) begin
      rsp_valid[last.id[IDX_W-1:0]] = 1'b1;
      rsp_y                         = fadd_y;
      rsp_tag                       = last.tag[TAG_W-1:0];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      busy = busy | shadow[s].v;
    end
  end

endmodule

// File: tb/tb_fadd_issue_arbiter.sv
// Directed bench for fadd_issue_arbiter with a 2-cycle behavioural fadd
// attached; every expected value below is worked out by hand.
module tb_fadd_issue_arbiter;

  localparam int NREQ  = 2;
  localparam int TAG_W = 6;

  localparam logic [31:0] F_ONE   = 32'h3F800000;
  localparam logic [31:0] F_TWO   = 32'h40000000;
  localparam logic [31:0] F_THREE = 32'h40400000;
  localparam logic [31:0] F_FIVE  = 32'h40A00000;
  localparam logic [31:0] F_MTWO  = 32'hC0000000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*32-1:0]    req_x1;
  logic [NREQ*32-1:0]    req_x2;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic                  flush;
  logic [31:0]           fadd_x1;
  logic [31:0]           fadd_x2;
  logic [31:0]           fadd_y;
  logic [NREQ-1:0]       rsp_valid;
  logic [31:0]           rsp_y;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  busy;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  fadd_issue_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_tag   (req_tag),
    .flush     (flush),
    .fadd_x1   (fadd_x1),
    .fadd_x2   (fadd_x2),
    .fadd_y    (fadd_y),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  // Behavioural fadd for normal numbers and zero, exact for the operands used here.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic [31:0] faddStage;
  always @(posedge clk) begin
    faddStage <= r2f(f2r(fadd_x1) + f2r(fadd_x2));
    fadd_y    <= faddStage;
  end

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, observed, expected);
  endtask

  // Drives one cycle of inputs just after the falling edge, then settles.
  task automatic applyStimulus(input logic r, input logic f, input logic [1:0] v,
                               input logic [31:0] a0, input logic [31:0] b0, input logic [5:0] t0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic [5:0] t1);
    @(negedge clk);
    rst       = r;
    flush     = f;
    req_valid = v;
    req_x1    = {a1, a0};
    req_x2    = {b1, b0};
    req_tag   = {t1, t0};
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'h0, 32'h0, 32'h0, 6'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0;
    req_x1 = '0; req_x2 = '0; req_tag = '0;

    // Reset holds off every grant even with both requesters valid.
    applyStimulus(1'b1, 1'b0, 2'b11, F_ONE, F_TWO, 6'h01, F_TWO, F_THREE, 6'h02);
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_fadd_x1", fadd_x1, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 6'h0, 32'h0, 32'h0, 6'h0);

    // Single op from requester 0: 1.0 + 2.0 returns two edges later.
    applyStimulus(1'b0, 1'b0, 2'b01, F_ONE, F_TWO, 6'h2A, 32'h0, 32'h0, 6'h0);
    checkOutput("t1_ready", 32'(req_ready), 32'h1);
    checkOutput("t1_fadd_x1", fadd_x1, F_ONE);
    checkOutput("t1_fadd_x2", fadd_x2, F_TWO);
    checkOutput("t1_busy0", 32'(busy), 32'h0);
    checkOutput("t1_rsp0", 32'(rsp_valid), 32'h0);
    idleCycle();
    checkOutput("t1_busy1", 32'(busy), 32'h1);
    checkOutput("t1_rsp1", 32'(rsp_valid), 32'h0);
    idleCycle();
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t1_rsp_y", rsp_y, F_THREE);
    checkOutput("t1_rsp_tag", 32'(rsp_tag), 32'h2A);
    checkOutput("t1_busy2", 32'(busy), 32'h1);
    idleCycle();
    checkOutput("t1_rsp_done", 32'(rsp_valid), 32'h0);
    checkOutput("t1_rsp_y0", rsp_y, 32'h0);
    checkOutput("t1_rsp_tag0", 32'(rsp_tag), 32'h0);
    checkOutput("t1_busy3", 32'(busy), 32'h0);

    // Both requesters always valid: strict alternation starting at 0, no idle slot.
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 6'h0, 32'h0, 32'h0, 6'h0);
    for (int k = 0; k < 10; k++) begin
      int j;
      if (k < 6)
        applyStimulus(1'b0, 1'b0, 2'b11, F_ONE, F_ONE, 6'(8'h10 + k / 2),
                      F_TWO, F_THREE, 6'(8'h20 + k / 2));
      else
        idleCycle();
      if (k < 6)
        checkOutput("t2_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      j = k - 2;
      if (j >= 0 && j < 6) begin
        checkOutput("t2_rsp_valid", 32'(rsp_valid), (j % 2 == 0) ? 32'h1 : 32'h2);
        checkOutput("t2_rsp_tag", 32'(rsp_tag), (j % 2 == 0) ? 32'(8'h10 + j / 2) : 32'(8'h20 + j / 2));
        checkOutput("t2_rsp_y", rsp_y, (j % 2 == 0) ? F_TWO : F_FIVE);
      end else if (j >= 6) begin
        checkOutput("t2_rsp_idle", 32'(rsp_valid), 32'h0);
      end
    end

    // Requester 1 alone: four back-to-back grants, 2.0 + -2.0 = 0.
    for (int k = 0; k < 6; k++) begin
      if (k < 4)
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 6'h0, F_TWO, F_MTWO, 6'(8'h30 + k));
      else
        idleCycle();
      if (k < 4) checkOutput("t3_ready", 32'(req_ready), 32'h2);
      if (k >= 2) begin
        checkOutput("t3_rsp_valid", 32'(rsp_valid), 32'h2);
        checkOutput("t3_rsp_tag", 32'(rsp_tag), 32'(8'h30 + k - 2));
        checkOutput("t3_rsp_y", rsp_y, 32'h0);
      end
    end

    // Flush right after the second issue: first result still delivered, second lost.
    applyStimulus(1'b0, 1'b0, 2'b01, F_ONE, F_TWO, 6'h05, 32'h0, 32'h0, 6'h0);
    checkOutput("t4_ready0", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 6'h0, F_TWO, F_THREE, 6'h06);
    checkOutput("t4_ready1", 32'(req_ready), 32'h2);
    applyStimulus(1'b0, 1'b1, 2'b01, F_ONE, F_ONE, 6'h07, 32'h0, 32'h0, 6'h0);
    checkOutput("t4_flush_ready", 32'(req_ready), 32'h0);
    checkOutput("t4_flush_x1", fadd_x1, 32'h0);
    checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t4_rsp_tag", 32'(rsp_tag), 32'h05);
    checkOutput("t4_rsp_y", rsp_y, F_THREE);
    idleCycle();
    checkOutput("t4_squashed", 32'(rsp_valid), 32'h0);
    checkOutput("t4_busy", 32'(busy), 32'h0);
    idleCycle();
    checkOutput("t4_quiet", 32'(rsp_valid), 32'h0);

    // Reset with two ops in flight and both requesters valid.
    applyStimulus(1'b0, 1'b0, 2'b11, F_ONE, F_TWO, 6'h08, F_TWO, F_THREE, 6'h09);
    checkOutput("t5_ready0", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 1'b0, 2'b11, F_ONE, F_ONE, 6'h0A, F_TWO, F_THREE, 6'h09);
    checkOutput("t5_ready1", 32'(req_ready), 32'h2);
    applyStimulus(1'b1, 1'b0, 2'b11, F_ONE, F_ONE, 6'h0A, F_TWO, F_THREE, 6'h09);
    checkOutput("t5_rst_ready", 32'(req_ready), 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b11, F_ONE, F_ONE, 6'h0A, F_TWO, F_THREE, 6'h09);
    checkOutput("t5_post_busy", 32'(busy), 32'h0);
    checkOutput("t5_post_rsp", 32'(rsp_valid), 32'h0);
    checkOutput("t5_post_ready", 32'(req_ready), 32'h1);
    idleCycle();
    checkOutput("t5_rsp_none", 32'(rsp_valid), 32'h0);
    checkOutput("t5_busy", 32'(busy), 32'h1);
    idleCycle();
    checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t5_rsp_tag", 32'(rsp_tag), 32'h0A);
    checkOutput("t5_rsp_y", rsp_y, F_TWO);

    // Idle stretch; the pointer must still favour requester 1 afterwards.
    for (int k = 0; k < 10; k++) begin
      idleCycle();
      checkOutput("t6_fadd_x1", fadd_x1, 32'h0);
      checkOutput("t6_fadd_x2", fadd_x2, 32'h0);
      checkOutput("t6_rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("t6_busy", 32'(busy), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 2'b11, F_ONE, F_ONE, 6'h0B, F_TWO, F_TWO, 6'h0C);
    checkOutput("t6_ptr_held", 32'(req_ready), 32'h2);
    idleCycle();
    idleCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
